// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types, constants and helpers for the sequential BCD converter
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [3:0] DD_ADD3   = 4'd3;
  localparam logic [3:0] DD_THRESH = 4'd5;

  // Smallest width able to count 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/dd_digit_adjust.sv
// rtl/dd_digit_adjust.sv - double-dabble add-3 correction for one BCD digit
module dd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  logic [3:0] sum;
  logic       carry;

  rca4 u_add3 (
    .a    (digit_i),
    .b    (DD_ADD3),
    .cin  (1'b0),
    .sum  (sum),
    .cout (carry)
  );

  // Apply +3 for digits 5 and above; a carry only occurs for out-of-range
  // digits, which are then passed through untouched.
  always_comb begin
    digit_o = digit_i;
    if ((digit_i >= DD_THRESH) && !carry) begin
      digit_o = sum;
    end
  end

endmodule

// File: rtl/rca4.sv
// rtl/rca4.sv - 4-bit ripple-carry adder
module rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  // Full-adder chain, carry rippling from bit 0 upward.
  always_comb begin
    c[0] = cin;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[4];
  end

endmodule

// File: rtl/bcd_seq_converter.sv
// rtl/bcd_seq_converter.sv - sequential double-dabble binary-to-BCD converter; optional BCD_SEQ_SIGNED_EN
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
`ifdef BCD_SEQ_SIGNED_EN
  output logic                  out_neg,
`endif
  output logic                  busy
);

  localparam int CNT_W = cnt_width(BIN_W);
  localparam int BCD_W = 4 * DIGITS;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   out_bcd_q, out_bcd_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [BCD_W-1:0]   adj;
  logic [BIN_W-1:0]   load_val;

  // One add-3 corrector per scratch digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    dd_digit_adjust u_adj (
      .digit_i (scratch_q[4*g +: 4]),
      .digit_o (adj[4*g +: 4])
    );
  end

`ifdef BCD_SEQ_SIGNED_EN
  logic neg_q, neg_d;

  // Magnitude of the two's-complement operand; the most negative value
  // maps onto 2^(BIN_W-1), which still fits the unsigned shift register.
  always_comb begin
    load_val = in_bin;
    if (in_bin[BIN_W-1]) begin
      load_val = ~in_bin + 1'b1;
    end
  end

  assign out_neg = neg_q;
`else
  // Unsigned operand loads straight into the shift register.
  always_comb begin
    load_val = in_bin;
  end
`endif

  // Next-state and datapath: accept in IDLE, one shift-and-add-3 per CONV cycle.
  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    scratch_d = scratch_q;
    out_bcd_d = out_bcd_q;
    count_d   = count_q;
`ifdef BCD_SEQ_SIGNED_EN
    neg_d     = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          bin_d     = load_val;
          scratch_d = '0;
          count_d   = '0;
          state_d   = CONV;
`ifdef BCD_SEQ_SIGNED_EN
          neg_d     = in_bin[BIN_W-1];
`endif
        end
      end
      CONV: begin
        scratch_d = {adj[BCD_W-2:0], bin_q[BIN_W-1]};
        bin_d     = {bin_q[BIN_W-2:0], 1'b0};
        count_d   = count_q + 1'b1;
        if (count_q == LAST_CNT) begin
          out_bcd_d = scratch_d;
          count_d   = '0;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      out_bcd_q <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      scratch_q <= scratch_d;
      out_bcd_q <= out_bcd_d;
      count_q   <= count_d;
    end
  end

`ifdef BCD_SEQ_SIGNED_EN
  // Sign flag captured at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= neg_d;
    end
  end
`endif

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == CONV);
  assign out_valid = (state_q == DONE);
  assign out_bcd   = out_bcd_q;

endmodule

// File: tb/tb_bcd_seq_converter.sv
// tb/tb_bcd_seq_converter.sv - directed and sweep bench for bcd_seq_converter
module tb_bcd_seq_converter;

  localparam int BIN_W  = 8;
  localparam int DIGITS = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [7:0]  in_bin = 8'd0;
  logic        in_ready;
  logic        out_valid;
  logic        busy;
  logic [11:0] out_bcd;
`ifdef BCD_SEQ_SIGNED_EN
  logic        out_neg;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_seq_converter #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
`ifdef BCD_SEQ_SIGNED_EN
    .out_neg   (out_neg),
`endif
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input logic [7:0] v);
    int m;
    m = int'(v);
`ifdef BCD_SEQ_SIGNED_EN
    if (v[7]) m = 256 - int'(v);
`endif
    return {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  function automatic logic ref_neg(input logic [7:0] v);
`ifdef BCD_SEQ_SIGNED_EN
    return v[7];
`else
    return 1'b0;
`endif
  endfunction

  task automatic do_conv(input logic [7:0] v, input logic [11:0] exp, input logic exp_neg,
                         input int stall, input bit inject, input string tag);
    int n;
    logic [11:0] held;
    check({tag, "_rdy_pre"}, 32'(in_ready), 32'd1);
    in_bin    = v;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_bin   = 8'h5A;
    check({tag, "_busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin
      check({tag, "_rdy_conv"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(BIN_W));
    check({tag, "_bcd"}, 32'(out_bcd), 32'(exp));
`ifdef BCD_SEQ_SIGNED_EN
    check({tag, "_neg"}, 32'(out_neg), 32'(exp_neg));
`else
    check({tag, "_neg"}, 32'(1'b0), 32'(exp_neg));
`endif
    check({tag, "_rdy_done"}, 32'(in_ready), 32'd0);
    held = exp;
    for (int s = 0; s < stall; s++) begin
      if (inject) begin
        in_valid = 1'b1;
        in_bin   = 8'd7;
      end
      @(posedge clk); #1;
      check({tag, "_stall_vld"}, 32'(out_valid), 32'd1);
      check({tag, "_stall_bcd"}, 32'(out_bcd), 32'(held));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
    check({tag, "_rdy_post"}, 32'(in_ready), 32'd1);
    check({tag, "_busy_post"}, 32'(busy), 32'd0);
    check({tag, "_bcd_keep"}, 32'(out_bcd), 32'(exp));
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out_bcd", 32'(out_bcd), 32'd0);
`ifdef BCD_SEQ_SIGNED_EN
    check("rst_out_neg", 32'(out_neg), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;

`ifdef BCD_SEQ_SIGNED_EN
    do_conv(8'd255, 12'h001, 1'b1, 0, 1'b0, "b255");
`else
    do_conv(8'd255, 12'h255, 1'b0, 0, 1'b0, "b255");
`endif
    do_conv(8'd0,  12'h000, 1'b0, 0, 1'b0, "b0");
    do_conv(8'd99, 12'h099, 1'b0, 0, 1'b0, "b99");
`ifdef BCD_SEQ_SIGNED_EN
    do_conv(8'd128, 12'h128, 1'b1, 5, 1'b1, "b128");
`else
    do_conv(8'd128, 12'h128, 1'b0, 5, 1'b1, "b128");
`endif
    do_conv(8'd7, 12'h007, 1'b0, 0, 1'b0, "b7");

    in_bin   = 8'd200;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_out_bcd", 32'(out_bcd), 32'd0);
`ifdef BCD_SEQ_SIGNED_EN
    check("arst_out_neg", 32'(out_neg), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_conv(8'd42, 12'h042, 1'b0, 0, 1'b0, "b42");

`ifdef BCD_SEQ_SIGNED_EN
    do_conv(8'h80, 12'h128, 1'b1, 0, 1'b0, "s80");
    do_conv(8'hFF, 12'h001, 1'b1, 1, 1'b0, "sFF");
    do_conv(8'h7F, 12'h127, 1'b0, 0, 1'b0, "s7F");
`endif

    for (int v = 0; v < 256; v++) begin
      do_conv(8'(v), ref_bcd(8'(v)), ref_neg(8'(v)), int'($urandom_range(0, 2)), 1'b0, "sweep");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
- Sequential double-dabble converter: unsigned binary in, packed BCD out.
- Runs one shift-and-add-3 iteration per clock.
- All add-3 corrections are done by 4-bit ripple-carry adders, one per digit.
- Sits between the binary operand source and the BCD display/readout stage, with valid/ready handshakes on both sides.

Parameters:
- BIN_W, 8, binary input width in bits; also the number of iterations.
- DIGITS, 3, number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W - 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand present
- in_ready  output  1  converter can accept an operand
- in_bin  input  BIN_W  binary operand
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- out_bcd  output  4*DIGITS  packed BCD result; digit 0 (units) is in bits [3:0]
- busy  output  1  high while in state CONV

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_bcd=0, iteration counter=0, scratch register=0.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready at edge E0: load bin shift reg=in_bin, clear BCD scratch, count=0, go to CONV.
  - CONV: in_ready=0, busy=1. At each edge E1..E(BIN_W):
    - every scratch digit >=5 gets +3 via its digit adjuster;
    - then {scratch,bin} shifts left by 1;
    - count increments.
  - After the edge where count reaches BIN_W-1 (edge E(BIN_W)): copy scratch into out_bcd, go to DONE.
  - DONE: out_valid=1, in_ready=0. out_bcd is stable while out_valid is high. On out_ready: go to IDLE, clear out_valid. out_bcd keeps its last value.
- Latency: out_valid rises BIN_W cycles after the accept edge (8 at default). Throughput is one conversion per BIN_W+2 cycles minimum.
- in_valid while not in IDLE: ignored; the operand is not latched.
- out_ready while not in DONE: ignored.
- out_ready asserted on the same edge DONE is entered: no effect until the next edge. out_valid is high for at least one cycle.
- Adjust arithmetic:
  - Adder operands are the 4-bit digit, B=4'd3, cin=0.
  - Carry-out is discarded; it cannot be set for inputs 5..9.
  - Digits never exceed 9 at adjust time.
- Reset asserted mid-CONV or mid-DONE: immediate return to reset values; no partial result is visible.

Optional Feature:
- Macro: BCD_SEQ_SIGNED_EN.
- With the macro defined:
  - in_bin is two's complement.
  - Adds port out_neg (output, 1 bit), reset value 0. It is latched at accept as in_bin[BIN_W-1] and is valid alongside out_bcd.
  - Magnitude = negated in_bin when negative; it is computed at accept and loaded into the shift register.
  - -2^(BIN_W-1) yields magnitude 2^(BIN_W-1), which fits the unsigned shift register.
- Without the macro: in_bin is unsigned, no out_neg port, no negation logic.

Decomposition:
- Shared package bcd_pkg:
  - state encoding type (IDLE, CONV, DONE);
  - constants DD_ADD3=4'd3 and DD_THRESH=4'd5;
  - function computing counter width clog2(BIN_W).
- One sub-module: dd_digit_adjust.
  - 4-bit in, 4-bit out.
  - Compares against DD_THRESH and instantiates the existing 4-bit ripple-carry adder with B=DD_ADD3, cin=0.
  - Instantiated DIGITS times in a generate loop.

Test Plan:
- Reset, then in_bin=8'd255 with out_ready=1:
  - out_valid rises exactly 8 cycles after accept;
  - out_bcd=12'h255;
  - one-cycle out_valid pulse.
- in_bin=0, then in_bin=8'd99, back-to-back with out_ready=1:
  - out_bcd=12'h000, then 12'h099;
  - in_ready low throughout CONV and DONE.
- in_bin=8'd128 with out_ready=0 for 5 cycles after out_valid:
  - out_bcd=12'h128, stable during the stall;
  - a new in_valid with in_bin=8'd7 during the stall is ignored;
  - after out_ready, the next accepted operand converts correctly.
- Accept in_bin=8'd200, assert rst_n=0 at iteration 4:
  - all outputs return to reset values asynchronously;
  - after release, in_bin=8'd42 gives 12'h042.
- Exhaustive sweep 0..255 with random out_ready stalls: every out_bcd matches a reference decimal model.
- BCD_SEQ_SIGNED_EN defined:
  - in_bin=8'h80 -> out_neg=1, out_bcd=12'h128;
  - in_bin=8'hFF -> out_neg=1, 12'h001;
  - in_bin=8'h7F -> out_neg=0, 12'h127.
